mem_port_arbiter: RTL and testbench
===================================

Name: mem_port_arbiter

Overview:
- Arbitrates the single main-memory port between the instruction-fetch requester and the load/store-unit requester.
- Allows one outstanding transaction at a time, routes the response to the requester that owns it, and prevents fetch starvation.
- Sits between the IF/Mem stages and the DRAM model; replaces the shared grant wire.

Parameters:
- ADDR_W, 32, address width of both requesters and the memory port
- DATA_W, 32, data width for read and write data
- STARVE_LIMIT, 4, consecutive lost contested arbitrations after which fetch gets priority; legal range 1..15
- TIMEOUT_CYCLES, 64, response timeout in cycles; used only with ARB_TIMEOUT_EN

Ports:
- clock  in  1  system clock; all state updates on rising edge
- reset  in  1  synchronous, active-low reset
- instr_req_ip  in  1  fetch read request
- instr_addr_ip  in  ADDR_W  fetch address
- instr_gnt_op  out  1  fetch request accepted this cycle
- instr_rvalid_op  out  1  fetch response valid
- instr_rdata_op  out  DATA_W  fetch response data
- data_req_ip  in  1  LSU request
- data_we_ip  in  1  1 = store, 0 = load
- data_addr_ip  in  ADDR_W  LSU address
- data_wdata_ip  in  DATA_W  store data
- data_gnt_op  out  1  LSU request accepted this cycle
- data_rvalid_op  out  1  LSU response valid; load data or store acknowledge
- data_rdata_op  out  DATA_W  load data
- mem_req_op  out  1  request to memory
- mem_we_op  out  1  write enable to memory
- mem_addr_op  out  ADDR_W  memory address
- mem_wdata_op  out  DATA_W  memory write data
- mem_gnt_ip  in  1  memory accepts the request this cycle
- mem_rvalid_ip  in  1  memory response valid
- mem_rdata_ip  in  DATA_W  memory response data
- timeout_err_op  out  1  one-cycle pulse on a response timeout

Behaviour:
- FSM states: IDLE, BUSY_I (fetch outstanding), BUSY_D (LSU outstanding). State is registered.
- While reset is 0 at the clock edge, the block enters IDLE and clears the starve counter and timeout counter.
- While reset is 0, all outputs are forced to 0, including the combinational outputs.

IDLE:
- mem_req_op = instr_req_ip | data_req_ip.
- Selection: the LSU wins by default. The fetch requester wins when only it requests, or when starve_cnt == STARVE_LIMIT.
- The selected requester's addr, we and wdata drive the mem_* outputs. For fetch, mem_we_op = 0 and mem_wdata_op = 0.
- Grant: `<sel>_gnt_op = mem_gnt_ip & mem_req_op & selected`. This is combinational, with zero-cycle accept.
- On a grant, the next state is BUSY_I or BUSY_D. With no grant, the FSM stays in IDLE and requesters must hold their request stable.

BUSY_x:
- mem_req_op = 0 and both gnt outputs are 0.
- On mem_rvalid_ip, the owner sees `<x>_rvalid_op = 1` and `<x>_rdata_op = mem_rdata_ip` in the same cycle (combinational pass-through). The next state is IDLE.
- The non-owner's rvalid stays 0 and its rdata output is 0.

Ordering and latency:
- The minimum transaction is 2 cycles: grant, then response at the earliest one cycle later.
- There is one bubble cycle between back-to-back transactions, because a new request is issued only from IDLE.

Starve counter (4 bits, saturating at STARVE_LIMIT):
- Increments when both requests are present and the LSU is granted.
- Clears to 0 on any fetch grant.
- Holds otherwise.

Boundary conditions:
- mem_rvalid_ip while in IDLE: ignored and dropped; no rvalid is produced.
- A requester deasserting its request before grant is legal; arbitration re-evaluates every IDLE cycle.
- mem_gnt_ip while mem_req_op = 0: ignored.
- Reset mid-transaction: returns to IDLE; the late response arriving afterwards is dropped per the IDLE rule.

Optional Feature:
- Macro: ARB_TIMEOUT_EN.
- Defined:
  - An 8-bit counter clears on entry to BUSY_x and increments each BUSY cycle without mem_rvalid_ip.
  - When the count reaches TIMEOUT_CYCLES-1 without a response, timeout_err_op pulses for 1 cycle and the FSM returns to IDLE.
  - The owner receives no rvalid for that transaction.
- Not defined: the counter is absent, BUSY waits indefinitely, and timeout_err_op is tied to 0.

Test Plan:
- Fetch only, instr_addr 0x10, mem_gnt same cycle, mem_rdata 0xDEADBEEF one cycle later -> instr_gnt=1 in cycle 0; instr_rvalid=1 with rdata 0xDEADBEEF in cycle 1; data_rvalid stays 0.
- Simultaneous data load at 0x200 and fetch at 0x14 -> data granted first (mem_addr=0x200, mem_we=0); fetch granted in the first IDLE cycle after the data response.
- STARVE_LIMIT=4, both requesting continuously, memory always ready with 1-cycle response -> grant sequence D,D,D,D,I,D,D,D,D,I; starve counter returns to 0 after each I.
- Store: data_we=1, addr 0x204, wdata 0x0000_00AB -> mem_we=1, mem_wdata=0xAB; data_rvalid acknowledge when mem_rvalid asserts.
- reset=0 asserted while in BUSY_D, then mem_rvalid arrives after reset=1 -> no rvalid on either port; next fetch request is granted normally.
- With ARB_TIMEOUT_EN, TIMEOUT_CYCLES=8, no mem_rvalid -> timeout_err_op pulses for 1 cycle 8 cycles after grant; FSM is in IDLE and accepts a new request. Without the macro, timeout_err_op stays 0 and the FSM stays in BUSY.

Source files
------------

// File: rtl/mem_port_arbiter.sv
// rtl/mem_port_arbiter.sv - single memory port arbiter for fetch and LSU requesters (optional feature macro: ARB_TIMEOUT_EN)
module mem_port_arbiter #(
  parameter int ADDR_W         = 32,
  parameter int DATA_W         = 32,
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              instr_req_ip,
  input  logic [ADDR_W-1:0] instr_addr_ip,
  output logic              instr_gnt_op,
  output logic              instr_rvalid_op,
  output logic [DATA_W-1:0] instr_rdata_op,
  input  logic              data_req_ip,
  input  logic              data_we_ip,
  input  logic [ADDR_W-1:0] data_addr_ip,
  input  logic [DATA_W-1:0] data_wdata_ip,
  output logic              data_gnt_op,
  output logic              data_rvalid_op,
  output logic [DATA_W-1:0] data_rdata_op,
  output logic              mem_req_op,
  output logic              mem_we_op,
  output logic [ADDR_W-1:0] mem_addr_op,
  output logic [DATA_W-1:0] mem_wdata_op,
  input  logic              mem_gnt_ip,
  input  logic              mem_rvalid_ip,
  input  logic [DATA_W-1:0] mem_rdata_ip,
  output logic              timeout_err_op
);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_BUSY_I = 2'd1,
    ST_BUSY_D = 2'd2
  } state_e;

  // The starve counter is 4 bits wide and the timeout counter 8 bits wide.
  if (STARVE_LIMIT < 1 || STARVE_LIMIT > 15) begin : g_bad_starve_limit
    $error("STARVE_LIMIT must be in 1..15");
  end
  if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be in 1..256");
  end

  localparam logic [3:0] STARVE_MAX = 4'(STARVE_LIMIT);

  state_e     state_q, state_d;
  logic [3:0] starve_q, starve_d;
  logic       sel_i, sel_d;
`ifdef ARB_TIMEOUT_EN
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYCLES - 1);
  logic [7:0] tmo_q, tmo_d;
`endif

  // Arbitration, request steering, response routing and next-state logic.
  always_comb begin
    state_d         = state_q;
    starve_d        = starve_q;
    sel_i           = 1'b0;
    sel_d           = 1'b0;
    instr_gnt_op    = 1'b0;
    instr_rvalid_op = 1'b0;
    instr_rdata_op  = '0;
    data_gnt_op     = 1'b0;
    data_rvalid_op  = 1'b0;
    data_rdata_op   = '0;
    mem_req_op      = 1'b0;
    mem_we_op       = 1'b0;
    mem_addr_op     = '0;
    mem_wdata_op    = '0;
    timeout_err_op  = 1'b0;
`ifdef ARB_TIMEOUT_EN
    tmo_d           = tmo_q;
`endif

    case (state_q)
      ST_IDLE: begin
        // LSU wins unless fetch is alone or has been starved long enough.
        sel_i = instr_req_ip & (~data_req_ip | (starve_q == STARVE_MAX));
        sel_d = data_req_ip & ~sel_i;
        mem_req_op = sel_i | sel_d;
        if (sel_i) begin
          mem_addr_op = instr_addr_ip;
        end else if (sel_d) begin
          mem_addr_op  = data_addr_ip;
          mem_we_op    = data_we_ip;
          mem_wdata_op = data_wdata_ip;
        end
        instr_gnt_op = mem_gnt_ip & sel_i;
        data_gnt_op  = mem_gnt_ip & sel_d;
        if (instr_gnt_op) begin
          state_d  = ST_BUSY_I;
          starve_d = 4'd0;
        end else if (data_gnt_op) begin
          state_d = ST_BUSY_D;
          if (instr_req_ip && (starve_q < STARVE_MAX)) begin
            starve_d = starve_q + 4'd1;
          end
        end
`ifdef ARB_TIMEOUT_EN
        if (instr_gnt_op || data_gnt_op) begin
          tmo_d = 8'd0;
        end
`endif
      end
      ST_BUSY_I, ST_BUSY_D: begin
        if (mem_rvalid_ip) begin
          if (state_q == ST_BUSY_I) begin
            instr_rvalid_op = 1'b1;
            instr_rdata_op  = mem_rdata_ip;
          end else begin
            data_rvalid_op = 1'b1;
            data_rdata_op  = mem_rdata_ip;
          end
          state_d = ST_IDLE;
        end
`ifdef ARB_TIMEOUT_EN
        else if (tmo_q == TMO_LAST) begin
          timeout_err_op = 1'b1;
          state_d        = ST_IDLE;
        end else begin
          tmo_d = tmo_q + 8'd1;
        end
`endif
      end
      default: state_d = ST_IDLE;
    endcase

    // Reset silences every output, including the combinational paths.
    if (!reset) begin
      state_d         = ST_IDLE;
      starve_d        = 4'd0;
      instr_gnt_op    = 1'b0;
      instr_rvalid_op = 1'b0;
      instr_rdata_op  = '0;
      data_gnt_op     = 1'b0;
      data_rvalid_op  = 1'b0;
      data_rdata_op   = '0;
      mem_req_op      = 1'b0;
      mem_we_op       = 1'b0;
      mem_addr_op     = '0;
      mem_wdata_op    = '0;
      timeout_err_op  = 1'b0;
`ifdef ARB_TIMEOUT_EN
      tmo_d           = 8'd0;
`endif
    end
  end

  // State, starve counter and timeout counter registers.
  always_ff @(posedge clock) begin
    state_q  <= state_d;
    starve_q <= starve_d;
`ifdef ARB_TIMEOUT_EN
    tmo_q    <= tmo_d;
`endif
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb/tb_mem_port_arbiter.sv - self-checking bench for mem_port_arbiter
module tb_mem_port_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int SL = 4;
  localparam int TO = 8;
`ifdef ARB_TIMEOUT_EN
  localparam bit TMO_ON = 1'b1;
`else
  localparam bit TMO_ON = 1'b0;
`endif

  logic          clock = 1'b0;
  logic          reset;
  logic          instr_req_ip;
  logic [AW-1:0] instr_addr_ip;
  logic          instr_gnt_op, instr_rvalid_op;
  logic [DW-1:0] instr_rdata_op;
  logic          data_req_ip, data_we_ip;
  logic [AW-1:0] data_addr_ip;
  logic [DW-1:0] data_wdata_ip;
  logic          data_gnt_op, data_rvalid_op;
  logic [DW-1:0] data_rdata_op;
  logic          mem_req_op, mem_we_op;
  logic [AW-1:0] mem_addr_op;
  logic [DW-1:0] mem_wdata_op;
  logic          mem_gnt_ip, mem_rvalid_ip;
  logic [DW-1:0] mem_rdata_ip;
  logic          timeout_err_op;

  mem_port_arbiter #(
    .ADDR_W(AW), .DATA_W(DW), .STARVE_LIMIT(SL), .TIMEOUT_CYCLES(TO)
  ) dut (
    .clock(clock), .reset(reset),
    .instr_req_ip(instr_req_ip), .instr_addr_ip(instr_addr_ip),
    .instr_gnt_op(instr_gnt_op), .instr_rvalid_op(instr_rvalid_op),
    .instr_rdata_op(instr_rdata_op),
    .data_req_ip(data_req_ip), .data_we_ip(data_we_ip),
    .data_addr_ip(data_addr_ip), .data_wdata_ip(data_wdata_ip),
    .data_gnt_op(data_gnt_op), .data_rvalid_op(data_rvalid_op),
    .data_rdata_op(data_rdata_op),
    .mem_req_op(mem_req_op), .mem_we_op(mem_we_op),
    .mem_addr_op(mem_addr_op), .mem_wdata_op(mem_wdata_op),
    .mem_gnt_ip(mem_gnt_ip), .mem_rvalid_ip(mem_rvalid_ip),
    .mem_rdata_ip(mem_rdata_ip), .timeout_err_op(timeout_err_op)
  );

  always #5 clock = ~clock;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Transaction-level model: who owns the port, how long it has been out,
  // and how many contested rounds fetch has lost.
  int            m_owner = 0;  // 0 none, 1 fetch, 2 LSU
  int            m_starve = 0;
  int            m_age = 0;    // cycles since the grant
  int            n_owner, n_starve, n_age;
  bit            fetch_wins;
  logic          e_ig, e_dg, e_ir, e_dr, e_mreq, e_mwe, e_to;
  logic [DW-1:0] e_ird, e_drd, e_mwd;
  logic [AW-1:0] e_maddr;
  string         gnt_log = "";

  initial begin
    forever begin
      @(negedge clock);
      e_ig = 0; e_dg = 0; e_ir = 0; e_dr = 0; e_mreq = 0; e_mwe = 0; e_to = 0;
      e_ird = '0; e_drd = '0; e_mwd = '0; e_maddr = '0;
      n_owner = m_owner; n_starve = m_starve; n_age = m_age;
      if (!reset) begin
        n_owner = 0; n_starve = 0; n_age = 0;
      end else if (m_owner == 0) begin
        fetch_wins = instr_req_ip && (!data_req_ip || m_starve == SL);
        if (fetch_wins) begin
          e_mreq = 1; e_maddr = instr_addr_ip; e_ig = mem_gnt_ip;
          if (mem_gnt_ip) begin n_owner = 1; n_starve = 0; n_age = 1; end
        end else if (data_req_ip) begin
          e_mreq = 1; e_maddr = data_addr_ip; e_mwe = data_we_ip; e_mwd = data_wdata_ip;
          e_dg = mem_gnt_ip;
          if (mem_gnt_ip) begin
            n_owner = 2; n_age = 1;
            if (instr_req_ip) n_starve = (m_starve + 1 > SL) ? SL : m_starve + 1;
          end
        end
      end else begin
        if (mem_rvalid_ip) begin
          if (m_owner == 1) begin e_ir = 1; e_ird = mem_rdata_ip; end
          else begin e_dr = 1; e_drd = mem_rdata_ip; end
          n_owner = 0;
        end else if (TMO_ON && m_age == TO) begin
          e_to = 1; n_owner = 0;
        end else begin
          n_age = m_age + 1;
        end
      end
      chk("m_instr_gnt", instr_gnt_op, e_ig);
      chk("m_data_gnt", data_gnt_op, e_dg);
      chk("m_instr_rvalid", instr_rvalid_op, e_ir);
      chk("m_data_rvalid", data_rvalid_op, e_dr);
      chk("m_mem_req", mem_req_op, e_mreq);
      chk("m_timeout", timeout_err_op, e_to);
      if (!reset || e_ir || m_owner != 1) chk("m_instr_rdata", instr_rdata_op, e_ird);
      if (!reset || e_dr || m_owner != 2) chk("m_data_rdata", data_rdata_op, e_drd);
      if (!reset || e_mreq) begin
        chk("m_mem_addr", mem_addr_op, e_maddr);
        chk("m_mem_we", mem_we_op, e_mwe);
        chk("m_mem_wdata", mem_wdata_op, e_mwd);
      end
      if (instr_gnt_op) gnt_log = {gnt_log, "I"};
      if (data_gnt_op)  gnt_log = {gnt_log, "D"};
      @(posedge clock);
      m_owner = n_owner; m_starve = n_starve; m_age = n_age;
    end
  end

  task automatic step();
    @(posedge clock);
    #1;
  endtask

  task automatic quiet();
    instr_req_ip = 0; instr_addr_ip = '0;
    data_req_ip = 0; data_we_ip = 0; data_addr_ip = '0; data_wdata_ip = '0;
    mem_gnt_ip = 0; mem_rvalid_ip = 0; mem_rdata_ip = '0;
  endtask

  logic tmo_seen [1:12];
  logic dg_seen  [1:12];

  initial begin
    quiet();
    reset = 0;
    // Reset with every input active: nothing may leak out.
    instr_req_ip = 1; data_req_ip = 1; mem_gnt_ip = 1; mem_rvalid_ip = 1;
    mem_rdata_ip = 32'h1111_2222;
    @(negedge clock);
    chk("rst_mem_req", mem_req_op, 0);
    chk("rst_gnts", {instr_gnt_op, data_gnt_op}, 0);
    step(); step();
    quiet(); reset = 1; step();

    // Fetch only, response one cycle later.
    instr_req_ip = 1; instr_addr_ip = 32'h10; mem_gnt_ip = 1;
    @(negedge clock);
    chk("t1_instr_gnt", instr_gnt_op, 1);
    chk("t1_mem_addr", mem_addr_op, 32'h10);
    step();
    quiet(); mem_rvalid_ip = 1; mem_rdata_ip = 32'hDEADBEEF;
    @(negedge clock);
    chk("t1_instr_rvalid", instr_rvalid_op, 1);
    chk("t1_instr_rdata", instr_rdata_op, 32'hDEADBEEF);
    chk("t1_data_rvalid", data_rvalid_op, 0);
    step(); quiet();

    // Stray memory grant with no request, then a withheld grant.
    mem_gnt_ip = 1; step();
    mem_gnt_ip = 0; data_req_ip = 1; data_addr_ip = 32'h300;
    step(); step();
    @(negedge clock);
    chk("t2_no_gnt", data_gnt_op, 0);
    step();
    mem_gnt_ip = 1;
    @(negedge clock);
    chk("t2_late_gnt", data_gnt_op, 1);
    step();
    quiet(); mem_rvalid_ip = 1; mem_rdata_ip = 32'h55;
    step(); quiet();

    // Simultaneous load and fetch: LSU first, fetch after the bubble.
    data_req_ip = 1; data_addr_ip = 32'h200; instr_req_ip = 1; instr_addr_ip = 32'h14;
    mem_gnt_ip = 1;
    @(negedge clock);
    chk("t3_data_gnt", data_gnt_op, 1);
    chk("t3_instr_gnt0", instr_gnt_op, 0);
    chk("t3_mem_addr_d", mem_addr_op, 32'h200);
    chk("t3_mem_we", mem_we_op, 0);
    step();
    data_req_ip = 0; mem_rvalid_ip = 1; mem_rdata_ip = 32'h1234;
    @(negedge clock);
    chk("t3_data_rvalid", data_rvalid_op, 1);
    step();
    mem_rvalid_ip = 0;
    @(negedge clock);
    chk("t3_instr_gnt", instr_gnt_op, 1);
    chk("t3_mem_addr_i", mem_addr_op, 32'h14);
    step();
    quiet(); mem_rvalid_ip = 1; mem_rdata_ip = 32'h5678;
    @(negedge clock);
    chk("t3_instr_rvalid", instr_rvalid_op, 1);
    step(); quiet();

    // Continuous contention with an always-ready memory.
    gnt_log = "";
    instr_req_ip = 1; instr_addr_ip = 32'h40; data_req_ip = 1; data_addr_ip = 32'h400;
    mem_gnt_ip = 1; mem_rvalid_ip = 1;
    for (int i = 0; i < 20; i++) begin
      mem_rdata_ip = 32'(i + 100);
      step();
    end
    quiet();
    total++;
    if (gnt_log != "DDDDIDDDDI") begin
      bad++;
      $display("FAIL t4_grant_seq: got %s expected DDDDIDDDDI", gnt_log);
    end

    // Store with acknowledge.
    data_req_ip = 1; data_we_ip = 1; data_addr_ip = 32'h204; data_wdata_ip = 32'h0000_00AB;
    mem_gnt_ip = 1;
    @(negedge clock);
    chk("t5_data_gnt", data_gnt_op, 1);
    chk("t5_mem_we", mem_we_op, 1);
    chk("t5_mem_wdata", mem_wdata_op, 32'hAB);
    step();
    quiet(); mem_rvalid_ip = 1;
    @(negedge clock);
    chk("t5_ack", data_rvalid_op, 1);
    step(); quiet();

    // Reset while a load is outstanding; the late response is dropped.
    data_req_ip = 1; data_addr_ip = 32'h208; mem_gnt_ip = 1;
    @(negedge clock);
    chk("t6_data_gnt", data_gnt_op, 1);
    step();
    quiet(); reset = 0;
    step();
    reset = 1; mem_rvalid_ip = 1; mem_rdata_ip = 32'hBAD0_BAD0;
    @(negedge clock);
    chk("t6_late_rvalid", {instr_rvalid_op, data_rvalid_op}, 0);
    step();
    quiet(); instr_req_ip = 1; instr_addr_ip = 32'h18; mem_gnt_ip = 1;
    @(negedge clock);
    chk("t6_instr_gnt", instr_gnt_op, 1);
    step();
    quiet(); mem_rvalid_ip = 1; mem_rdata_ip = 32'h77;
    @(negedge clock);
    chk("t6_instr_rvalid", instr_rvalid_op, 1);
    step(); quiet();

    // No response: timeout with the feature, indefinite wait without it.
    instr_req_ip = 1; instr_addr_ip = 32'h20; mem_gnt_ip = 1;
    @(negedge clock);
    chk("t7_instr_gnt", instr_gnt_op, 1);
    step();
    instr_req_ip = 0; data_req_ip = 1; data_addr_ip = 32'h220;
    for (int k = 1; k <= 12; k++) begin
      @(negedge clock);
      tmo_seen[k] = timeout_err_op;
      dg_seen[k]  = data_gnt_op;
      step();
    end
    for (int k = 1; k <= 12; k++) begin
`ifdef ARB_TIMEOUT_EN
      chk($sformatf("t7_timeout_c%0d", k), tmo_seen[k], (k == 8));
      chk($sformatf("t7_data_gnt_c%0d", k), dg_seen[k], (k == 9));
`else
      chk($sformatf("t7_timeout_c%0d", k), tmo_seen[k], 0);
      chk($sformatf("t7_data_gnt_c%0d", k), dg_seen[k], 0);
`endif
    end
    quiet(); mem_rvalid_ip = 1;
    step();
    quiet(); step(); step();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
